// File: rtl/mcntrl_wbuf_paged.sv
// Paged write-channel buffer for the mcntrl sequencer.
// A narrow producer fills pages one after another; the sequencer reads
// each committed page as wide words and releases it. Page occupancy is
// tracked here and drives the ready handshakes and sticky error flags.

// One lane of the wide read word: a WDATA_WIDTH slice of the memory that
// holds write words whose in-word position equals the lane index.
module mcntrl_wbuf_paged_lane #(
    parameter int W  = 32,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [0:(1<<AW)-1];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port; both ports update on the same edge, so a same-address
    // read returns the old contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

module mcntrl_wbuf_paged #(
    parameter int WDATA_WIDTH = 32,
    parameter int RATIO_LOG2  = 1,
    parameter int PAGE_LOG2   = 7,
    parameter int NPAGES_LOG2 = 2,
    parameter int REGISTERS   = 1
) (
    input  logic                              mclk,
    input  logic                              mrst_n,
    input  logic [WDATA_WIDTH-1:0]            wdata,
    input  logic                              we,
    input  logic                              wpage_done,
    output logic                              wr_ready,
    input  logic                              raddr_reset,
    input  logic                              skip_reset,
    input  logic                              rd,
    input  logic                              rpage_done,
    output logic                              rd_ready,
    output logic [(WDATA_WIDTH<<RATIO_LOG2)-1:0] data_out,
    output logic                              data_valid,
    output logic [NPAGES_LOG2:0]              pages_full,
    input  logic                              err_clr,
    output logic                              err_wovf,
    output logic                              err_rund
);
    localparam int RATIO  = 1 << RATIO_LOG2;
    localparam int WCW    = PAGE_LOG2 + RATIO_LOG2;
    localparam int AW     = NPAGES_LOG2 + PAGE_LOG2;
    localparam int NPAGES = 1 << NPAGES_LOG2;
    localparam int STAGES = 1 + REGISTERS;

    logic [NPAGES_LOG2-1:0]           wpage, rpage;
    logic [WCW-1:0]                   wcnt;
    logic [PAGE_LOG2-1:0]             wrow;
    logic [PAGE_LOG2-1:0]             raddr;
    logic                             skip_r;
    logic [RATIO-1:0]                 lane_we;
    logic [RATIO-1:0][WDATA_WIDTH-1:0] lane_q;
    logic [STAGES:1]                  vld_q;
    logic [STAGES:0]                  vld_pipe;
    logic                             wr_acc, wdone, rdone;

    assign wr_ready = pages_full < (NPAGES_LOG2+1)'(NPAGES);
    assign rd_ready = pages_full != '0;
    assign wr_acc   = we && wr_ready;
    assign wdone    = wpage_done && wr_ready;
    assign rdone    = rpage_done && rd_ready;
    assign vld_pipe = {vld_q, rd};
    assign data_valid = vld_pipe[STAGES];

    // Split the in-page write count into the row and the lane it selects
    generate
        if (RATIO_LOG2 == 0) begin : g_one_lane
            assign wrow       = wcnt;
            assign lane_we[0] = wr_acc;
        end else begin : g_lanes
            assign wrow = wcnt[WCW-1:RATIO_LOG2];
            for (genvar i = 0; i < RATIO; i++) begin : g_we
                assign lane_we[i] = wr_acc && (wcnt[RATIO_LOG2-1:0] == RATIO_LOG2'(i));
            end
        end
    endgenerate

    generate
        for (genvar i = 0; i < RATIO; i++) begin : g_lane
            mcntrl_wbuf_paged_lane #(.W(WDATA_WIDTH), .AW(AW)) u_lane (
                .clk   (mclk),
                .rst_n (mrst_n),
                .we    (lane_we[i]),
                .waddr ({wpage, wrow}),
                .wdata (wdata),
                .re    (rd),
                .raddr ({rpage, raddr}),
                .rdata (lane_q[i])
            );
        end
    endgenerate

    // Optional output register, loaded only when a read reaches it
    generate
        if (REGISTERS != 0) begin : g_oreg
            logic [(WDATA_WIDTH<<RATIO_LOG2)-1:0] out_q;
            always_ff @(posedge mclk or negedge mrst_n) begin
                if (!mrst_n)          out_q <= '0;
                else if (vld_pipe[1]) out_q <= lane_q;
            end
            assign data_out = out_q;
        end else begin : g_noreg
            assign data_out = lane_q;
        end
    endgenerate

    // Read-valid shift register tracking the read latency
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) vld_q <= '0;
        else         vld_q <= vld_pipe[STAGES-1:0];
    end

    // Write side: in-page counter and page pointer
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            wcnt  <= '0;
            wpage <= '0;
        end else if (wdone) begin
            wcnt  <= '0;
            wpage <= wpage + NPAGES_LOG2'(1);
        end else if (wr_acc) begin
            wcnt  <= wcnt + WCW'(1);
        end
    end

    // Read side: address rewind (unless skipped), increment, page release
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            raddr  <= '0;
            rpage  <= '0;
            skip_r <= 1'b0;
        end else begin
            skip_r <= skip_reset;
            if (rdone) begin
                raddr <= '0;
                rpage <= rpage + NPAGES_LOG2'(1);
            end else if (raddr_reset && !skip_r) begin
                raddr <= '0;
            end else if (rd) begin
                raddr <= raddr + PAGE_LOG2'(1);
            end
        end
    end

    // Committed-page count; simultaneous commit and release cancel out
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) pages_full <= '0;
        else if (wdone && !rdone) pages_full <= pages_full + (NPAGES_LOG2+1)'(1);
        else if (rdone && !wdone) pages_full <= pages_full - (NPAGES_LOG2+1)'(1);
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            err_wovf <= 1'b0;
            err_rund <= 1'b0;
        end else begin
            err_wovf <= (err_wovf && !err_clr) || ((we || wpage_done) && !wr_ready);
            err_rund <= (err_rund && !err_clr) || ((rd || rpage_done) && !rd_ready);
        end
    end
endmodule
